// File: rtl/fp_wb_arbiter_pkg.sv
// Shared constants and the buffered writeback entry type for the FP writeback arbiter.
package fp_wb_pkg;

  localparam int unsigned NUM_SRC     = 3;
  localparam int unsigned BUF_DEPTH   = 2;
  localparam int unsigned FLEN        = 32;
  localparam int unsigned TAG_W       = 4;
  localparam int unsigned FREG_ADDR_W = 5;
  localparam int unsigned FFLAGS_W    = 5;

  typedef struct packed {
    logic [FREG_ADDR_W-1:0] rd;
    logic [FLEN-1:0]        data;
    logic [TAG_W-1:0]       tag;
    logic [FFLAGS_W-1:0]    fflags;
  } wb_entry_t;

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Producer-side result handshakes plus register-file write / completion broadcast signals.
interface fp_wb_arbiter_if
  import fp_wb_pkg::*;
();

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC*FREG_ADDR_W-1:0] src_rd;
  logic [NUM_SRC*FLEN-1:0]        src_data;
  logic [NUM_SRC*TAG_W-1:0]       src_tag;
  logic [NUM_SRC*FFLAGS_W-1:0]    src_fflags;

  logic                   wr_enable;
  logic [FREG_ADDR_W-1:0] wr_addr;
  logic [FLEN-1:0]        wr_data;
  logic                   wb_valid;
  logic [TAG_W-1:0]       wb_tag;
  logic [FFLAGS_W-1:0]    wb_fflags;

  modport master (
    output src_valid, src_rd, src_data, src_tag, src_fflags,
    input  src_ready, wr_enable, wr_addr, wr_data, wb_valid, wb_tag, wb_fflags
  );

  modport slave (
    input  src_valid, src_rd, src_data, src_tag, src_fflags,
    output src_ready, wr_enable, wr_addr, wr_data, wb_valid, wb_tag, wb_fflags
  );

endinterface

// File: rtl/fp_wb_arbiter_fifo.sv
// Per-source circular result buffer; flush clears occupancy and pointers, storage is left as-is.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output logic      empty,
  output logic      full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign head_entry = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: per-source FIFOs, round-robin grant, registered single write port.
module fp_wb_arbiter
  import fp_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  fp_wb_arbiter_if.slave     bus
);

  localparam int unsigned RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  wb_entry_t          push_entry [NUM_SRC];
  wb_entry_t          head_entry [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, empty, full;

  logic               grant_vld;
  logic [RW-1:0]      grant_idx;
  logic [RW-1:0]      cand;
  wb_entry_t          grant_entry;

  logic               wr_en_q;
  wb_entry_t          out_q;
  logic [RW-1:0]      rr_ptr_q, rr_ptr_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push_entry[i] = '{
      rd:     bus.src_rd[i*FREG_ADDR_W +: FREG_ADDR_W],
      data:   bus.src_data[i*FLEN +: FLEN],
      tag:    bus.src_tag[i*TAG_W +: TAG_W],
      fflags: bus.src_fflags[i*FFLAGS_W +: FFLAGS_W]
    };
    // Pushes offered during a flush are dropped rather than landing in a just-cleared FIFO.
    assign push[i] = bus.src_valid[i] & ~full[i] & ~flush;
    assign pop[i]  = grant_vld & (grant_idx == RW'(i));

    fp_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push[i]),
      .push_entry (push_entry[i]),
      .pop        (pop[i]),
      .head_entry (head_entry[i]),
      .empty      (empty[i]),
      .full       (full[i])
    );
  end

  assign bus.src_ready = ~full;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = RW'((32'(rr_ptr_q) + k) % NUM_SRC);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_entry = head_entry[grant_idx];
    rr_ptr_d    = (grant_idx == RW'(NUM_SRC - 1)) ? '0 : grant_idx + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q  <= 1'b0;
      out_q    <= '0;
      rr_ptr_q <= '0;
    end else if (flush) begin
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= grant_vld;
      if (grant_vld) begin
        out_q    <= grant_entry;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  assign bus.wr_enable = wr_en_q;
  assign bus.wb_valid  = wr_en_q;
  assign bus.wr_addr   = out_q.rd;
  assign bus.wr_data   = out_q.data;
  assign bus.wb_tag    = out_q.tag;
  assign bus.wb_fflags = out_q.fflags;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: directed pushes queue expected writes, a monitor compares them.
module tb_fp_wb_arbiter;
  import fp_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  fp_wb_arbiter_if bus ();

  fp_wb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        failures = 0;
  wb_entry_t sb [$];
  wb_entry_t mon_exp;
  logic      seen_dead = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      check("wb_valid_eq_wr_enable", 64'(bus.wb_valid), 64'(bus.wr_enable));
      if (bus.wr_enable) begin
        if (bus.wr_data == 32'hDEAD) seen_dead = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h expected=none",
                   {bus.wr_addr, bus.wr_data, bus.wb_tag, bus.wb_fflags});
        end else begin
          mon_exp = sb.pop_front();
          check("write_fields", 64'({bus.wr_addr, bus.wr_data, bus.wb_tag, bus.wb_fflags}),
                64'(mon_exp));
        end
      end
    end
  end

  task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d,
                         input logic [3:0] t, input logic [4:0] f);
    bus.src_rd[i*5 +: 5]      = rd;
    bus.src_data[i*32 +: 32]  = d;
    bus.src_tag[i*4 +: 4]     = t;
    bus.src_fflags[i*5 +: 5]  = f;
  endtask

  task automatic issue(input int i, input logic [4:0] rd, input logic [31:0] d,
                       input logic [3:0] t, input logic [4:0] f);
    set_src(i, rd, d, t, f);
    bus.src_valid[i] = 1'b1;
    sb.push_back('{rd: rd, data: d, tag: t, fflags: f});
  endtask

  // pattern bit k is the required wr_enable in cycle k+1 after the push cycle
  task automatic check_we_seq(input string name, input logic [7:0] pattern, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(name, 64'(bus.wr_enable), 64'(pattern[k]));
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [2:0] acc;
  int         cnt [2];
  logic       ever_full;
  localparam int N = 5;

  initial begin
    bus.src_valid = '0;
    bus.src_rd = '0;
    bus.src_data = '0;
    bus.src_tag = '0;
    bus.src_fflags = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus.wr_enable, bus.wb_valid, bus.wr_addr, bus.wr_data,
                                bus.wb_tag, bus.wb_fflags}), 64'd0);
    check("reset_src_ready", 64'(bus.src_ready), 64'h7);
    rst = 1'b1;

    // 1: single push, two-cycle latency
    @(posedge clk); #1;
    issue(0, 5'd5, 32'h3F800000, 4'd3, 5'd0);
    @(posedge clk); #1;
    bus.src_valid = '0;
    check_we_seq("t1_latency", 8'b010, 3);
    drain("t1_drain");

    // 2a: src1+src2 together -> 1 then 2 on consecutive cycles
    @(posedge clk); #1;
    issue(1, 5'd1, 32'h11, 4'd1, 5'd1);
    issue(2, 5'd2, 32'h22, 4'd2, 5'd2);
    @(posedge clk); #1;
    bus.src_valid = '0;
    check_we_seq("t2a_timing", 8'b0110, 4);
    drain("t2a_drain");

    // 2b: all three together -> 0, 1, 2
    @(posedge clk); #1;
    issue(0, 5'd8, 32'h100, 4'd4, 5'd4);
    issue(1, 5'd9, 32'h101, 4'd5, 5'd8);
    issue(2, 5'd10, 32'h102, 4'd6, 5'd16);
    @(posedge clk); #1;
    bus.src_valid = '0;
    check_we_seq("t2b_timing", 8'b01110, 5);
    drain("t2b_drain");

    // 3: src0/src1 streaming with backpressure, strict alternation expected
    for (int k = 1; k <= N; k++) begin
      sb.push_back('{rd: 5'd10, data: 32'(k), tag: 4'd0, fflags: 5'd0});
      sb.push_back('{rd: 5'd11, data: 32'(k), tag: 4'd1, fflags: 5'd0});
    end
    cnt[0] = 0;
    cnt[1] = 0;
    ever_full = 1'b0;
    @(posedge clk); #1;
    set_src(0, 5'd10, 32'd1, 4'd0, 5'd0);
    set_src(1, 5'd11, 32'd1, 4'd1, 5'd0);
    bus.src_valid = 3'b011;
    for (int cyc = 0; cyc < 60 && bus.src_valid != 3'b000; cyc++) begin
      @(negedge clk);
      acc = bus.src_valid & bus.src_ready;
      if ((bus.src_valid & ~bus.src_ready) != 3'b000) ever_full = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          cnt[i]++;
          if (cnt[i] == N) bus.src_valid[i] = 1'b0;
          else set_src(i, 5'(10 + i), 32'(cnt[i] + 1), 4'(i), 5'd0);
        end
      end
    end
    bus.src_valid = '0;
    check("t3_accepted", 64'({32'(cnt[0]), 32'(cnt[1])}), 64'({32'(N), 32'(N)}));
    check("t3_ready_dropped", 64'(ever_full), 64'd1);
    drain("t3_drain");

    // 4: fill, then flush with a concurrent src0 push of 0xDEAD
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) set_src(i, 5'(20 + i), 32'hA0 + 32'(i), 4'(8 + i), 5'(i + 1));
    bus.src_valid = 3'b111;
    sb.push_back('{rd: 5'd22, data: 32'hA2, tag: 4'd10, fflags: 5'd3});
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) set_src(i, 5'(24 + i), 32'hB0 + 32'(i), 4'(12 + i), 5'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    bus.src_valid = 3'b001;
    set_src(0, 5'd31, 32'hDEAD, 4'd15, 5'd31);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.src_valid = '0;
    @(negedge clk);
    check("t4_ready_after_flush", 64'(bus.src_ready), 64'h7);
    for (int k = 0; k < 4; k++) begin
      check("t4_idle_after_flush", 64'(bus.wr_enable), 64'd0);
      @(negedge clk);
    end
    drain("t4_drain");

    // 5: rd=0 still broadcast
    @(posedge clk); #1;
    issue(2, 5'd0, 32'h4040_0000, 4'd7, 5'b00001);
    @(posedge clk); #1;
    bus.src_valid = '0;
    check_we_seq("t5_timing", 8'b010, 3);
    drain("t5_drain");

    // 6: async reset while streaming
    for (int k = 0; k < 4; k++) begin
      issue(0, 5'd3, 32'h200 + 32'(k), 4'(k), 5'd0);
      @(posedge clk); #1;
    end
    bus.src_valid = '0;
    check("t6_streaming", 64'(bus.wr_enable), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("t6_async_outputs", 64'({bus.wr_enable, bus.wb_valid, bus.wr_addr, bus.wr_data,
                                   bus.wb_tag, bus.wb_fflags}), 64'd0);
    check("t6_async_ready", 64'(bus.src_ready), 64'h7);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 5'd7, 32'h55, 4'd2, 5'd2);
    @(posedge clk); #1;
    bus.src_valid = '0;
    check_we_seq("t6_latency", 8'b010, 3);
    drain("t6_drain");

    check("no_dead_written", 64'(seen_dead), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
